// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signal bundle of the store buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          isLd;
  logic          isSt;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] ld_data;
  logic          stall;
  logic          mem_isLd;
  logic          mem_isSt;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  isLd, isSt, address, data_in, mem_data_out,
    output ld_data, stall, mem_isLd, mem_isSt, mem_address, mem_data_in, empty, count
  );

  modport master (
    output isLd, isSt, address, data_in, mem_data_out,
    input  ld_data, stall, mem_isLd, mem_isSt, mem_address, mem_data_in, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: loads own the memory port, stores queue in a FIFO
// and drain on idle cycles or when full; loads forward from the youngest match.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          push, pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full      = (count_q == CW'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == bus.address) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
    end
  end

  // NOTE: every output gets a default first so no branch can leave one unassigned and infer a latch.
  always_comb begin
    bus.stall       = 1'b0;
    bus.ld_data     = '0;
    bus.mem_isLd    = 1'b0;
    bus.mem_isSt    = 1'b0;
    bus.mem_address = '0;
    bus.mem_data_in = '0;
    push            = 1'b0;
    pop             = 1'b0;

    if (full) begin
      // A full buffer forces a drain, so a stalled request is accepted next cycle.
      bus.mem_isSt    = 1'b1;
      bus.mem_address = addr_q[head_q];
      bus.mem_data_in = data_q[head_q];
      pop             = 1'b1;
      bus.stall       = bus.isLd | bus.isSt;
    end else if (bus.isSt) begin
      push = 1'b1;
    end else if (bus.isLd) begin
      bus.mem_isLd    = 1'b1;
      bus.mem_address = bus.address;
      bus.ld_data     = fwd_hit ? fwd_data : bus.mem_data_out;
    end else if (count_q != '0) begin
      bus.mem_isSt    = 1'b1;
      bus.mem_address = addr_q[head_q];
      bus.mem_data_in = data_q[head_q];
      pop             = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (push) begin
      tail_q  <= tail_q + PW'(1);
      count_q <= count_q + CW'(1);
    end else if (pop) begin
      head_q  <= head_q + PW'(1);
      count_q <= count_q - CW'(1);
    end
  end

  // NOTE: entry storage has no reset; stale contents are never visible because
  // forwarding and draining only look at entries counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.address;
      data_q[tail_q] <= bus.data_in;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a memory model plus a scoreboard of
// expected memory writes in program order, popped whenever the buffer drains.
module tb_store_buffer;
  logic clk;
  logic rst_n;

  store_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words read as 0x5A5A00xx so they never look like store data.
  bit [31:0] mem [256];
  bit        wr  [256];
  logic [7:0] mem_idx;
  assign mem_idx = bus.mem_address[7:0];
  assign bus.mem_data_out = wr[mem_idx] ? mem[mem_idx] : {24'h5A5A00, mem_idx};

  always @(posedge clk) begin
    if (bus.mem_isSt) begin
      mem[bus.mem_address[7:0]] <= bus.mem_data_in;
      wr[bus.mem_address[7:0]]  <= 1'b1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic set_in(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d);
    bus.isLd    = ld;
    bus.isSt    = st;
    bus.address = a;
    bus.data_in = d;
  endtask

  // Called at a negedge: scoreboard the drain (if any), then advance past the next posedge.
  task automatic step();
    wr_t e;
    if (sb.size() == 0) begin
      checks++;
      if (bus.mem_isSt !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_drain got mem_isSt=%b addr=%h exp no write", bus.mem_isSt, bus.mem_address);
      end
    end else if (bus.mem_isSt === 1'b1) begin
      e = sb.pop_front();
      checks++;
      if (bus.mem_address !== e.addr || bus.mem_data_in !== e.data) begin
        errors++;
        $display("FAIL drain_order got %h<-%h exp %h<-%h", bus.mem_address, bus.mem_data_in, e.addr, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    set_in(1'b0, 1'b1, a, d);
    sb.push_back('{addr: a, data: d});
    @(negedge clk);
    step();
  endtask

  task automatic drain_all();
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.empty === 1'b1) break;
      step();
    end
    checks++;
    if (bus.empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_all got empty=%b pending=%0d exp empty=1 pending=0", bus.empty, sb.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 32'h8, 32'h11);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_count got count=%0d empty=%b exp 0/1", bus.count, bus.empty);
    end
    checks++;
    if (bus.mem_isSt !== 1'b0 || bus.mem_isLd !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got st=%b ld=%b stall=%b exp 0/0/0", bus.mem_isSt, bus.mem_isLd, bus.stall);
    end
    checks++;
    if (bus.ld_data !== 32'h0 || bus.mem_address !== 32'h0 || bus.mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got ld=%h addr=%h din=%h exp zeros", bus.ld_data, bus.mem_address, bus.mem_data_in);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back('{addr: 32'h8, data: 32'h11});
    @(negedge clk);
    step();
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd1) begin
      errors++;
      $display("FAIL first_enqueue got count=%0d exp 1", bus.count);
    end
    step();
    drain_all();
  endtask

  task automatic test_single_drain();
    store(32'h10, 32'hAA);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_isSt !== 1'b1 || bus.mem_address !== 32'h10 || bus.mem_data_in !== 32'hAA) begin
      errors++;
      $display("FAIL single_drain got st=%b %h<-%h exp 1 00000010<-000000aa", bus.mem_isSt, bus.mem_address, bus.mem_data_in);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty got count=%0d empty=%b exp 0/1", bus.count, bus.empty);
    end
    step();
  endtask

  task automatic test_forwarding();
    store(32'h20, 32'h5);
    store(32'h20, 32'h7);
    set_in(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ld_data !== 32'h7 || bus.stall !== 1'b0 || bus.mem_isLd !== 1'b1 || bus.mem_isSt !== 1'b0) begin
      errors++;
      $display("FAIL fwd_youngest got ld=%h stall=%b ld=%b st=%b exp 7/0/1/0", bus.ld_data, bus.stall, bus.mem_isLd, bus.mem_isSt);
    end
    step();
    drain_all();
    set_in(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_isLd !== 1'b1 || bus.ld_data !== 32'h7) begin
      errors++;
      $display("FAIL load_after_drain got mem_isLd=%b ld=%h exp 1/00000007", bus.mem_isLd, bus.ld_data);
    end
    step();
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) store(32'(i), 32'(i + 1));
    set_in(1'b0, 1'b1, 32'h4, 32'h5);
    sb.push_back('{addr: 32'h4, data: 32'h5});
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd4 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL full_stall got count=%0d stall=%b exp 4/1", bus.count, bus.stall);
    end
    checks++;
    if (bus.mem_isSt !== 1'b1 || bus.mem_address !== 32'h0 || bus.mem_data_in !== 32'h1 || bus.ld_data !== 32'h0) begin
      errors++;
      $display("FAIL full_drain got st=%b %h<-%h ld=%h exp 1 0<-1 ld=0", bus.mem_isSt, bus.mem_address, bus.mem_data_in, bus.ld_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd3 || bus.stall !== 1'b0 || bus.mem_isSt !== 1'b0) begin
      errors++;
      $display("FAIL retry_accept got count=%0d stall=%b st=%b exp 3/0/0", bus.count, bus.stall, bus.mem_isSt);
    end
    step();
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.count !== 3'd4) begin
      errors++;
      $display("FAIL refill got count=%0d exp 4", bus.count);
    end
    step();
    drain_all();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr[i] !== 1'b1 || mem[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL mem_contents addr=%0d got wr=%b data=%h exp %h", i, wr[i], mem[i], i + 1);
      end
    end
  endtask

  task automatic test_miss_and_wrap();
    for (int i = 0; i < 3; i++) store(32'h50 + 32'(i), 32'h100 + 32'(i));
    drain_all();
    for (int i = 0; i < 2; i++) store(32'h60 + 32'(i), 32'h200 + 32'(i));
    drain_all();
    store(32'h30, 32'h9);
    set_in(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_isLd !== 1'b1 || bus.mem_address !== 32'h40 || bus.ld_data !== 32'h5A5A0040 || bus.mem_isSt !== 1'b0) begin
      errors++;
      $display("FAIL load_miss got ld=%b addr=%h data=%h st=%b exp 1/40/5a5a0040/0", bus.mem_isLd, bus.mem_address, bus.ld_data, bus.mem_isSt);
    end
    step();
    set_in(1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ld_data !== 32'h9) begin
      errors++;
      $display("FAIL load_hit_wrapped got %h exp 00000009", bus.ld_data);
    end
    step();
    set_in(1'b1, 1'b0, 32'h1000_0030, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ld_data !== 32'h5A5A0030) begin
      errors++;
      $display("FAIL full_width_compare got %h exp 5a5a0030", bus.ld_data);
    end
    step();
    drain_all();
  endtask

  task automatic test_ld_st_both();
    set_in(1'b1, 1'b1, 32'h70, 32'h77);
    sb.push_back('{addr: 32'h70, data: 32'h77});
    @(negedge clk);
    checks++;
    if (bus.ld_data !== 32'h0 || bus.mem_isLd !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL ld_st_both got ld=%h mem_isLd=%b stall=%b exp 0/0/0", bus.ld_data, bus.mem_isLd, bus.stall);
    end
    step();
    set_in(1'b1, 1'b0, 32'h70, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ld_data !== 32'h77) begin
      errors++;
      $display("FAIL ld_st_stored got %h exp 00000077", bus.ld_data);
    end
    step();
    drain_all();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) store(32'h80 + 32'(i), 32'hE1 + 32'(i));
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got count=%0d empty=%b exp 0/1", bus.count, bus.empty);
    end
    #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step();
    end
    checks++;
    if (wr[8'h80] || wr[8'h81] || wr[8'h82]) begin
      errors++;
      $display("FAIL discarded_stores got written=%b%b%b exp 000", wr[8'h80], wr[8'h81], wr[8'h82]);
    end
    checks++;
    if (mem[8'h20] !== 32'h7 || mem[8'h70] !== 32'h77) begin
      errors++;
      $display("FAIL mem_kept got %h/%h exp 00000007/00000077", mem[8'h20], mem[8'h70]);
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_forwarding();
    test_full_stall();
    test_miss_and_wrap();
    test_ld_st_both();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
